// File: rtl/uart_frame_rx.sv
// Framed command decoder: SOF | CMD | LEN | PAYLOAD[LEN] | CHK with XOR checksum.
// Good frames are copied from a staging buffer to the frame_* outputs with a one-cycle strobe.
module uart_frame_rx #(
    parameter logic [7:0] SOF         = 8'hA5,
    parameter int         MAX_LEN     = 4,
    parameter int         TIMEOUT_CYC = 200000,
    localparam int        LEN_W       = $clog2(MAX_LEN + 1),
    localparam int        TMR_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   frame_valid,
    output logic [7:0]             frame_cmd,
    output logic [LEN_W-1:0]       frame_len,
    output logic [MAX_LEN*8-1:0]   frame_payload,
    output logic                   err_chk,
    output logic                   err_len,
    output logic                   err_timeout,
    output logic                   busy
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK} state_t;

    state_t                    state_q, state_d;
    logic [TMR_W-1:0]          tmr_q;
    logic [7:0]                chk_q;
    logic [7:0]                cmd_q;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          idx_q;
    logic [MAX_LEN-1:0][7:0]   stage_q;

    logic tmr_expired;
    logic good, bad_chk, bad_len, tmo;

    assign tmr_expired = (state_q != S_IDLE) && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
    assign busy        = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        good    = 1'b0;
        bad_chk = 1'b0;
        bad_len = 1'b0;
        tmo     = 1'b0;
        if (rx_valid) begin
            case (state_q)
                S_IDLE:    if (rx_data == SOF) state_d = S_CMD;
                S_CMD:     state_d = S_LEN;
                S_LEN: begin
                    if (rx_data == 8'h00) begin
                        state_d = S_CHK;
                    end else if (32'(rx_data) > MAX_LEN) begin
                        bad_len = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: if (idx_q == len_q - LEN_W'(1)) state_d = S_CHK;
                S_CHK: begin
                    if (rx_data == chk_q) good = 1'b1;
                    else                  bad_chk = 1'b1;
                    state_d = S_IDLE;
                end
                default:   state_d = S_IDLE;
            endcase
        end else if (tmr_expired) begin
            tmo     = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q         <= '0;
            chk_q         <= '0;
            cmd_q         <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            stage_q       <= '0;
            frame_valid   <= 1'b0;
            frame_cmd     <= '0;
            frame_len     <= '0;
            frame_payload <= '0;
            err_chk       <= 1'b0;
            err_len       <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            frame_valid <= good;
            err_chk     <= bad_chk;
            err_len     <= bad_len;
            err_timeout <= tmo;

            if (rx_valid || state_q == S_IDLE) tmr_q <= '0;
            else                               tmr_q <= tmr_q + TMR_W'(1);

            if (rx_valid) begin
                case (state_q)
                    S_IDLE: if (rx_data == SOF) stage_q <= '0;
                    S_CMD: begin
                        cmd_q <= rx_data;
                        chk_q <= rx_data;
                    end
                    S_LEN: begin
                        chk_q <= chk_q ^ rx_data;
                        len_q <= rx_data[LEN_W-1:0];
                        idx_q <= '0;
                    end
                    S_PAYLOAD: begin
                        chk_q <= chk_q ^ rx_data;
                        idx_q <= idx_q + LEN_W'(1);
                        for (int i = 0; i < MAX_LEN; i++)
                            if (idx_q == LEN_W'(i)) stage_q[i] <= rx_data;
                    end
                    default: ;
                endcase
            end

            if (good) begin
                frame_cmd     <= cmd_q;
                frame_len     <= len_q;
                frame_payload <= stage_q;
            end
        end
    end

endmodule
